imm_gen_pipe: RTL and testbench
===============================

// Module: imm_gen_pipe
// PURPOSE
//  Registered decode-stage immediate generator for RV32/RV64 datapaths.
//  Extracts and sign-extends I/S/B/U/J immediates and zero-extends shift amounts.
//  Reports the instruction format and flags unsupported opcodes.
//  Sits between fetch and register-read with a valid/ready elastic interface
//  (2-entry skid buffer), so upstream and downstream stalls never drop instructions.
// PARAMETERS
//  XLEN    64  datapath/immediate width; legal values 32 or 64 only
//  TAG_W   8   width of sideband tag (e.g. ROB id / PC index), passed through unchanged
// PORTS
//  clk         in   1      single clock, all state on rising edge
//  reset_n     in   1      asynchronous, active-low reset
//  in_valid    in   1      upstream instruction valid
//  in_ready    out  1      block can accept (registered, depends only on state)
//  in_instr    in   32     raw instruction word
//  in_tag      in   TAG_W  sideband tag
//  out_valid   out  1      result valid
//  out_ready   in   1      downstream accepts
//  out_imm     out  XLEN   generated immediate
//  out_fmt     out  3      0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SH (shift), 7 ILL
//  out_illegal out  1      opcode unsupported for this XLEN
//  out_tag     out  TAG_W  tag of the instruction in out_imm
// BEHAVIOUR
//  - Decode table (opcode = instr[6:0]):
//    0000011/1100111/1110011 -> I: sext(instr[31:20]).
//    0010011 -> I; funct3 001/101 -> SH: zext(instr[25:20]) for XLEN=64, zext(instr[24:20]) for 32.
//    0011011 -> I/SH as 0010011 with shamt instr[24:20]; legal only when XLEN=64, else ILL.
//    0100011 -> S: sext({instr[31:25],instr[11:7]}).
//    1100011 -> B: sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}).
//    0110111/0010111 -> U: sext({instr[31:12],12'b0}); sign-extends bit 31 on XLEN=64.
//    1101111 -> J: sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0}).
//    0110011/0111011 -> R: imm 0, not illegal (0111011 ILL when XLEN=32).
//    All others -> fmt 7, out_illegal 1, imm 0.
//  - Latency: exactly 1 cycle from input handshake (in_valid&in_ready) to out_valid, when buffer empty.
//  - Skid FSM: EMPTY (in_ready=1, out_valid=0), ONE (in_ready=1, out_valid=1), TWO (in_ready=0, out_valid=1).
//    EMPTY: in fire -> ONE.
//    ONE: in fire and no out fire -> TWO; out fire and no in fire -> EMPTY.
//    ONE: in and out fire in the same cycle -> stay ONE, output regs load the new entry.
//    TWO: out fire -> skid entry moves to output, ONE; in_valid ignored while in_ready=0.
//  - Ordering strictly FIFO; outputs hold stable while out_valid&!out_ready.
//  - Reset (async, any state, mid-transfer): state EMPTY, in_ready=1, out_valid=0.
//    Also on reset: out_imm/out_tag=0, out_fmt=0, out_illegal=0; buffered entries discarded.
//  - Decode is combinational on the input side; outputs are driven from registers only.
// CONFIGURATION
//  IMM_GEN_STATS_EN defined: adds output stat_illegal_cnt [15:0].
//    Increments on each out handshake with out_illegal=1; saturates at 16'hFFFF; reset to 0.
//  Not defined: port and counter absent; all other behaviour identical.
// TESTING (XLEN=64 unless stated)
//  1. in 0xFFF00093 (addi -1), out_ready=1 -> next cycle imm 0xFFFFFFFFFFFFFFFF, fmt 1.
//  2. 0xFE112E23 (sw -4) -> imm -4, fmt 2; 0xFE000CE3 (beq -8) -> imm -8, fmt 3; 0x0010006F (jal) -> imm 0x800, fmt 5.
//  3. 0x43F0D093 (srai x1,x1,63) -> imm 63, fmt 6; XLEN=32 with 0x0000001B -> out_illegal 1, fmt 7.
//  4. out_ready=0, offer 3 back-to-back -> 2 accepted, in_ready=0 cycle after 2nd.
//     Then out_ready=1 -> all 3 emitted in order, tags match, none lost or duplicated.
//  5. Steady stream with out_ready=1 -> one result per cycle; state stays ONE; throughput 100%.
//  6. In state TWO, pull reset_n low mid-cycle -> out_valid=0, in_ready=1 immediately; STATS: 0x7F x3 -> count 3.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// ============================================================================
// imm_gen_pipe: registered RV32/RV64 immediate generator behind a 2-entry skid buffer.
// Optional macro IMM_GEN_STATS_EN adds the stat_illegal_cnt output.
// Revision: 1.0
// ============================================================================
`default_nettype none

module imm_gen_pipe #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
`ifdef IMM_GEN_STATS_EN
  ,
  output logic [15:0]      stat_illegal_cnt
`endif
);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_SH  = 3'd6;
  localparam logic [2:0] FMT_ILL = 3'd7;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  // ---------------- input-side decode ----------------
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        is_shift_f3;
  logic [63:0] dec_imm64;
  logic [2:0]  dec_fmt;
  logic        dec_ill;
  logic [XLEN-1:0] dec_imm;

  assign opcode      = in_instr[6:0];
  assign funct3      = in_instr[14:12];
  assign is_shift_f3 = (funct3 == 3'b001) || (funct3 == 3'b101);

  // Immediates are built at 64 bits and truncated so one table serves both XLENs.
  always_comb begin
    dec_imm64 = 64'd0;
    dec_fmt   = FMT_ILL;
    dec_ill   = 1'b1;
    case (opcode)
      7'b0000011, 7'b1100111, 7'b1110011: begin
        dec_imm64 = {{52{in_instr[31]}}, in_instr[31:20]};
        dec_fmt   = FMT_I;
        dec_ill   = 1'b0;
      end
      7'b0010011: begin
        dec_ill = 1'b0;
        if (is_shift_f3) begin
          dec_fmt = FMT_SH;
          if (XLEN == 64) dec_imm64 = {58'd0, in_instr[25:20]};
          else            dec_imm64 = {59'd0, in_instr[24:20]};
        end else begin
          dec_fmt   = FMT_I;
          dec_imm64 = {{52{in_instr[31]}}, in_instr[31:20]};
        end
      end
      7'b0011011: begin
        if (XLEN == 64) begin
          dec_ill = 1'b0;
          if (is_shift_f3) begin
            dec_fmt   = FMT_SH;
            dec_imm64 = {59'd0, in_instr[24:20]};
          end else begin
            dec_fmt   = FMT_I;
            dec_imm64 = {{52{in_instr[31]}}, in_instr[31:20]};
          end
        end
      end
      7'b0100011: begin
        dec_imm64 = {{52{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        dec_fmt   = FMT_S;
        dec_ill   = 1'b0;
      end
      7'b1100011: begin
        dec_imm64 = {{51{in_instr[31]}}, in_instr[31], in_instr[7],
                     in_instr[30:25], in_instr[11:8], 1'b0};
        dec_fmt   = FMT_B;
        dec_ill   = 1'b0;
      end
      7'b0110111, 7'b0010111: begin
        dec_imm64 = {{32{in_instr[31]}}, in_instr[31:12], 12'd0};
        dec_fmt   = FMT_U;
        dec_ill   = 1'b0;
      end
      7'b1101111: begin
        dec_imm64 = {{43{in_instr[31]}}, in_instr[31], in_instr[19:12],
                     in_instr[20], in_instr[30:21], 1'b0};
        dec_fmt   = FMT_J;
        dec_ill   = 1'b0;
      end
      7'b0110011: begin
        dec_fmt = FMT_R;
        dec_ill = 1'b0;
      end
      7'b0111011: begin
        if (XLEN == 64) begin
          dec_fmt = FMT_R;
          dec_ill = 1'b0;
        end
      end
      default: begin
        dec_imm64 = 64'd0;
        dec_fmt   = FMT_ILL;
        dec_ill   = 1'b1;
      end
    endcase
  end

  assign dec_imm = dec_imm64[XLEN-1:0];

  // ---------------- skid buffer ----------------
  state_t            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [XLEN-1:0]   out_imm_q, out_imm_d;
  logic [2:0]        out_fmt_q, out_fmt_d;
  logic              out_ill_q, out_ill_d;
  logic [TAG_W-1:0]  out_tag_q, out_tag_d;
  logic [XLEN-1:0]   skid_imm_q, skid_imm_d;
  logic [2:0]        skid_fmt_q, skid_fmt_d;
  logic              skid_ill_q, skid_ill_d;
  logic [TAG_W-1:0]  skid_tag_q, skid_tag_d;

  logic in_fire;
  logic out_fire;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;

  always_comb begin
    state_d    = state_q;
    out_imm_d  = out_imm_q;
    out_fmt_d  = out_fmt_q;
    out_ill_d  = out_ill_q;
    out_tag_d  = out_tag_q;
    skid_imm_d = skid_imm_q;
    skid_fmt_d = skid_fmt_q;
    skid_ill_d = skid_ill_q;
    skid_tag_d = skid_tag_q;
    case (state_q)
      S_EMPTY: begin
        if (in_fire) begin
          out_imm_d = dec_imm;
          out_fmt_d = dec_fmt;
          out_ill_d = dec_ill;
          out_tag_d = in_tag;
          state_d   = S_ONE;
        end
      end
      S_ONE: begin
        if (in_fire && !out_fire) begin
          skid_imm_d = dec_imm;
          skid_fmt_d = dec_fmt;
          skid_ill_d = dec_ill;
          skid_tag_d = in_tag;
          state_d    = S_TWO;
        end else if (out_fire && !in_fire) begin
          state_d = S_EMPTY;
        end else if (in_fire && out_fire) begin
          out_imm_d = dec_imm;
          out_fmt_d = dec_fmt;
          out_ill_d = dec_ill;
          out_tag_d = in_tag;
        end
      end
      S_TWO: begin
        if (out_fire) begin
          out_imm_d = skid_imm_q;
          out_fmt_d = skid_fmt_q;
          out_ill_d = skid_ill_q;
          out_tag_d = skid_tag_q;
          state_d   = S_ONE;
        end
      end
      default: state_d = S_EMPTY;
    endcase
    // Handshake flags are registered copies of the next state's decode.
    in_ready_d  = (state_d != S_TWO);
    out_valid_d = (state_d != S_EMPTY);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_imm_q   <= '0;
      out_fmt_q   <= FMT_R;
      out_ill_q   <= 1'b0;
      out_tag_q   <= '0;
      skid_imm_q  <= '0;
      skid_fmt_q  <= FMT_R;
      skid_ill_q  <= 1'b0;
      skid_tag_q  <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_imm_q   <= out_imm_d;
      out_fmt_q   <= out_fmt_d;
      out_ill_q   <= out_ill_d;
      out_tag_q   <= out_tag_d;
      skid_imm_q  <= skid_imm_d;
      skid_fmt_q  <= skid_fmt_d;
      skid_ill_q  <= skid_ill_d;
      skid_tag_q  <= skid_tag_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_imm     = out_imm_q;
  assign out_fmt     = out_fmt_q;
  assign out_illegal = out_ill_q;
  assign out_tag     = out_tag_q;

`ifdef IMM_GEN_STATS_EN
  logic [15:0] ill_cnt_q, ill_cnt_d;

  always_comb begin
    ill_cnt_d = ill_cnt_q;
    if (out_fire && out_ill_q && (ill_cnt_q != 16'hFFFF)) begin
      ill_cnt_d = ill_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ill_cnt_q <= 16'd0;
    end else begin
      ill_cnt_q <= ill_cnt_d;
    end
  end

  assign stat_illegal_cnt = ill_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: XLEN=64 main instance plus an XLEN=32 instance.
`default_nettype none

module tb_imm_gen_pipe;

  logic        clk;
  logic        reset_n;

  logic        in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [31:0] in_instr;
  logic [7:0]  in_tag, out_tag;
  logic [63:0] out_imm;
  logic [2:0]  out_fmt;

  logic        in_valid32, in_ready32, out_valid32, out_ready32, out_illegal32;
  logic [31:0] in_instr32;
  logic [7:0]  in_tag32, out_tag32;
  logic [31:0] out_imm32;
  logic [2:0]  out_fmt32;

`ifdef IMM_GEN_STATS_EN
  logic [15:0] stat_cnt, stat_cnt32;
`endif

  int checks;
  int passes;

  imm_gen_pipe #(.XLEN(64), .TAG_W(8)) u_dut64 (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_imm     (out_imm),
    .out_fmt     (out_fmt),
    .out_illegal (out_illegal),
    .out_tag     (out_tag)
`ifdef IMM_GEN_STATS_EN
    ,
    .stat_illegal_cnt (stat_cnt)
`endif
  );

  imm_gen_pipe #(.XLEN(32), .TAG_W(8)) u_dut32 (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid32),
    .in_ready    (in_ready32),
    .in_instr    (in_instr32),
    .in_tag      (in_tag32),
    .out_valid   (out_valid32),
    .out_ready   (out_ready32),
    .out_imm     (out_imm32),
    .out_fmt     (out_fmt32),
    .out_illegal (out_illegal32),
    .out_tag     (out_tag32)
`ifdef IMM_GEN_STATS_EN
    ,
    .stat_illegal_cnt (stat_cnt32)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] instr, input logic [7:0] tag);
    in_valid = 1'b1;
    in_instr = instr;
    in_tag   = tag;
    step();
  endtask

  task automatic chk_out(input string tag, input logic [63:0] imm, input logic [2:0] fmt,
                         input logic ill, input logic [7:0] t);
    chk({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
    chk({tag, "_imm"},   out_imm, imm);
    chk({tag, "_fmt"},   {61'd0, out_fmt}, {61'd0, fmt});
    chk({tag, "_ill"},   {63'd0, out_illegal}, {63'd0, ill});
    chk({tag, "_tag"},   {56'd0, out_tag}, {56'd0, t});
  endtask

  task automatic chk_out32(input string tag, input logic [31:0] imm, input logic [2:0] fmt,
                           input logic ill);
    chk({tag, "_valid"}, {63'd0, out_valid32}, 64'd1);
    chk({tag, "_imm"},   {32'd0, out_imm32}, {32'd0, imm});
    chk({tag, "_fmt"},   {61'd0, out_fmt32}, {61'd0, fmt});
    chk({tag, "_ill"},   {63'd0, out_illegal32}, {63'd0, ill});
  endtask

  initial begin
    checks      = 0;
    passes      = 0;
    reset_n     = 1'b0;
    in_valid    = 1'b0;
    in_instr    = 32'd0;
    in_tag      = 8'd0;
    out_ready   = 1'b0;
    in_valid32  = 1'b0;
    in_instr32  = 32'd0;
    in_tag32    = 8'd0;
    out_ready32 = 1'b0;
    step();
    step();

    // Reset state
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
    chk("rst_imm",       out_imm, 64'd0);
    chk("rst_fmt",       {61'd0, out_fmt}, 64'd0);
    chk("rst_ill",       {63'd0, out_illegal}, 64'd0);
    chk("rst_tag",       {56'd0, out_tag}, 64'd0);
    reset_n = 1'b1;
    step();

    // Streaming decode with out_ready=1: one result per cycle, state stays ONE
    out_ready = 1'b1;
    send(32'hFFF00093, 8'h01);
    chk_out("addi", 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0, 8'h01);
    chk("addi_in_ready", {63'd0, in_ready}, 64'd1);
    send(32'hFE112E23, 8'h02);
    chk_out("sw", 64'hFFFFFFFFFFFFFFFC, 3'd2, 1'b0, 8'h02);
    chk("sw_in_ready", {63'd0, in_ready}, 64'd1);
    send(32'hFE000CE3, 8'h03);
    chk_out("beq", 64'hFFFFFFFFFFFFFFF8, 3'd3, 1'b0, 8'h03);
    send(32'h0010006F, 8'h04);
    chk_out("jal", 64'h0000000000000800, 3'd5, 1'b0, 8'h04);
    send(32'h43F0D093, 8'h05);
    chk_out("srai", 64'd63, 3'd6, 1'b0, 8'h05);
    send(32'h800000B7, 8'h06);
    chk_out("lui", 64'hFFFFFFFF80000000, 3'd4, 1'b0, 8'h06);
    send(32'h003100B3, 8'h07);
    chk_out("add", 64'd0, 3'd0, 1'b0, 8'h07);
    send(32'h0000001B, 8'h08);
    chk_out("addiw64", 64'd0, 3'd1, 1'b0, 8'h08);
    send(32'h0000007F, 8'h09);
    chk_out("illop", 64'd0, 3'd7, 1'b1, 8'h09);
    chk("stream_in_ready", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b0;
    step();
    chk("drain_out_valid", {63'd0, out_valid}, 64'd0);

    // Backpressure: three offered, two accepted, FIFO order on release
    out_ready = 1'b0;
    send(32'h00500093, 8'h10);
    chk("bp1_in_ready", {63'd0, in_ready}, 64'd1);
    chk_out("bp1", 64'd5, 3'd1, 1'b0, 8'h10);
    send(32'hFE112E23, 8'h11);
    chk("bp2_in_ready", {63'd0, in_ready}, 64'd0);
    chk_out("bp2_hold", 64'd5, 3'd1, 1'b0, 8'h10);
    send(32'h0010006F, 8'h12);
    chk("bp3_in_ready", {63'd0, in_ready}, 64'd0);
    chk_out("bp3_hold", 64'd5, 3'd1, 1'b0, 8'h10);
    out_ready = 1'b1;
    step();
    chk_out("rel_b", 64'hFFFFFFFFFFFFFFFC, 3'd2, 1'b0, 8'h11);
    chk("rel_in_ready", {63'd0, in_ready}, 64'd1);
    step();
    chk_out("rel_c", 64'h800, 3'd5, 1'b0, 8'h12);
    in_valid = 1'b0;
    step();
    chk("rel_empty", {63'd0, out_valid}, 64'd0);

    // Asynchronous reset while in TWO
    out_ready = 1'b0;
    send(32'hFFF00093, 8'h20);
    send(32'hFE112E23, 8'h21);
    in_valid = 1'b0;
    chk("two_in_ready", {63'd0, in_ready}, 64'd0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_in_ready",  {63'd0, in_ready},  64'd1);
    chk("arst_tag",       {56'd0, out_tag}, 64'd0);
    chk("arst_imm",       out_imm, 64'd0);
    #1;
    reset_n = 1'b1;
    step();
    out_ready = 1'b1;
    step();
    chk("post_rst_empty", {63'd0, out_valid}, 64'd0);

    // Three illegal opcodes back to back
    send(32'h0000007F, 8'h30);
    send(32'h0000007F, 8'h31);
    chk_out("ill2", 64'd0, 3'd7, 1'b1, 8'h31);
    send(32'h0000007F, 8'h32);
    in_valid = 1'b0;
    step();
`ifdef IMM_GEN_STATS_EN
    chk("stat_cnt", {48'd0, stat_cnt}, 64'd3);
`endif
    chk("ill_drained", {63'd0, out_valid}, 64'd0);

    // XLEN=32 instance
    out_ready32 = 1'b1;
    in_valid32  = 1'b1;
    in_instr32  = 32'h0000001B;
    in_tag32    = 8'h40;
    step();
    chk_out32("x32_addiw", 32'd0, 3'd7, 1'b1);
    in_instr32 = 32'h43F0D093;
    step();
    chk_out32("x32_srai", 32'd31, 3'd6, 1'b0);
    in_instr32 = 32'h0000003B;
    step();
    chk_out32("x32_rw", 32'd0, 3'd7, 1'b1);
    in_instr32 = 32'h800000B7;
    step();
    chk_out32("x32_lui", 32'h80000000, 3'd4, 1'b0);
    in_valid32 = 1'b0;
    step();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
